// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: March C- element tables and FSM/element enums
// shared by ram_march_bist and ram_bist_cmp.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    E0, E1, E2, E3, E4, E5
  } elem_e;

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_e;

  // up: ascending address order
  // rd/wr: element contains a read / write op
  // rd_bg/wr_bg: background bit replicated over the word
  typedef struct packed {
    logic up;
    logic rd;
    logic wr;
    logic rd_bg;
    logic wr_bg;
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(elem_e e);
    elem_cfg_t c;
    c = '0;
    unique case (e)
      E0: c = '{up:1'b1, rd:1'b0, wr:1'b1,
                rd_bg:1'b0, wr_bg:1'b0};
      E1: c = '{up:1'b1, rd:1'b1, wr:1'b1,
                rd_bg:1'b0, wr_bg:1'b1};
      E2: c = '{up:1'b1, rd:1'b1, wr:1'b1,
                rd_bg:1'b1, wr_bg:1'b0};
      E3: c = '{up:1'b0, rd:1'b1, wr:1'b1,
                rd_bg:1'b0, wr_bg:1'b1};
      E4: c = '{up:1'b0, rd:1'b1, wr:1'b1,
                rd_bg:1'b1, wr_bg:1'b0};
      E5: c = '{up:1'b1, rd:1'b1, wr:1'b0,
                rd_bg:1'b0, wr_bg:1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic elem_e elem_next(elem_e e);
    elem_e n;
    n = E0;
    unique case (e)
      E0: n = E1;
      E1: n = E2;
      E2: n = E3;
      E3: n = E4;
      E4: n = E5;
      default: n = E0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: BIST <-> RAM core command/data bus.
// master: addr/wdata/cs/we out, rdata in; slave: mirror.
interface ram_bist_if #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8
);
  logic [ADDRWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0] wdata;
  logic                 cs;
  logic                 we;
  logic [DATAWIDTH-1:0] rdata;

  modport master (
    output addr,
    output wdata,
    output cs,
    output we,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  cs,
    input  we,
    output rdata
  );
endinterface

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: read-latency aligned compare pipe + first-fail capture.
// i_vld/i_addr/i_exp: issued read; i_rdata: RAM dataOut; o_fail*: result.
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDRWIDTH  = 4,
  parameter int DATAWIDTH  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_vld,
  input  logic [ADDRWIDTH-1:0] i_addr,
  input  logic [DATAWIDTH-1:0] i_exp,
  input  logic [DATAWIDTH-1:0] i_rdata,
  output logic                 o_fail,
  output logic [ADDRWIDTH-1:0] o_fail_addr,
  output logic [DATAWIDTH-1:0] o_fail_data
);

  localparam int L = RD_LATENCY;

  logic                 r_vld  [L];
  logic [ADDRWIDTH-1:0] r_addr [L];
  logic [DATAWIDTH-1:0] r_exp  [L];
  logic                 r_fail;
  logic [ADDRWIDTH-1:0] r_faddr;
  logic [DATAWIDTH-1:0] r_fdata;
  logic                 w_miss;

  // The pipe is fed from the registered RAM command, so the last
  // stage lines up with the cycle in which dataOut is valid.
  assign w_miss = r_vld[L-1] &&
                  (i_rdata != r_exp[L-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        r_vld[i]  <= 1'b0;
        r_addr[i] <= '0;
        r_exp[i]  <= '0;
      end
      r_fail  <= 1'b0;
      r_faddr <= '0;
      r_fdata <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < L; i++) begin
        r_vld[i]  <= 1'b0;
        r_addr[i] <= '0;
        r_exp[i]  <= '0;
      end
      r_fail  <= 1'b0;
      r_faddr <= '0;
      r_fdata <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_addr[0] <= i_addr;
      r_exp[0]  <= i_exp;
      for (int i = 1; i < L; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
        r_exp[i]  <= r_exp[i-1];
      end
      if (w_miss) begin
        r_fail <= 1'b1;
        // only the first miscompare is kept
        if (!r_fail) begin
          r_faddr <= r_addr[L-1];
          r_fdata <= i_rdata;
        end
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_faddr;
  assign o_fail_data = r_fdata;

endmodule

// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- BIST sequencer driving a single-port RAM.
// clk/rst_n/start in; ram bus (master); busy/done/fail/fail_addr/fail_data out.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDRWIDTH  = 4,
  parameter int DATAWIDTH  = 8,
  parameter int SIZE       = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  ram_bist_if.master           ram,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ADDRWIDTH-1:0] fail_addr,
  output logic [DATAWIDTH-1:0] fail_data
);

  localparam int AC  = ADDRWIDTH + 1;
  localparam int DCW = $clog2(RD_LATENCY + 1);

  localparam logic [AC-1:0] LAST = AC'(SIZE - 1);
  localparam logic [AC-1:0] ONE  = AC'(1);

  state_e                r_state;
  elem_e                 r_elem;
  logic [AC-1:0]         r_addr;
  logic                  r_sub;
  logic [DCW-1:0]        r_drain;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cs;
  logic                  r_we;
  logic [ADDRWIDTH-1:0]  r_oaddr;
  logic [DATAWIDTH-1:0]  r_wdata;
  logic [DATAWIDTH-1:0]  r_exp;

  state_e                w_state_nxt;
  elem_e                 w_elem_nxt;
  logic [AC-1:0]         w_addr_nxt;
  logic                  w_sub_nxt;
  logic [DCW-1:0]        w_drain_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_cs_nxt;
  logic                  w_we_nxt;
  logic [ADDRWIDTH-1:0]  w_oaddr_nxt;
  logic [DATAWIDTH-1:0]  w_wdata_nxt;
  logic [DATAWIDTH-1:0]  w_exp_nxt;
  logic                  w_clr;
  logic                  w_issue;
  elem_e                 w_src_elem;
  logic [AC-1:0]         w_src_addr;
  logic                  w_src_sub;
  elem_cfg_t             w_cfg;
  elem_cfg_t             w_ncfg;
  elem_e                 w_nelem;
  logic                  w_rd_op;
  logic                  w_last_sub;
  logic                  w_last_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_elem  <= E0;
      r_addr  <= '0;
      r_sub   <= 1'b0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_oaddr <= '0;
      r_wdata <= '0;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_addr  <= w_addr_nxt;
      r_sub   <= w_sub_nxt;
      r_drain <= w_drain_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cs    <= w_cs_nxt;
      r_we    <= w_we_nxt;
      r_oaddr <= w_oaddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_addr_nxt  = r_addr;
    w_sub_nxt   = r_sub;
    w_drain_nxt = r_drain;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_clr       = 1'b0;
    w_issue     = 1'b0;
    w_src_elem  = r_elem;
    w_src_addr  = r_addr;
    w_src_sub   = r_sub;
    w_cs_nxt    = 1'b0;
    w_we_nxt    = 1'b0;
    w_oaddr_nxt = '0;
    w_wdata_nxt = '0;
    w_exp_nxt   = '0;

    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_clr       = 1'b1;
          w_issue     = 1'b1;
          // first op goes out on the start edge itself
          w_src_elem  = E0;
          w_src_addr  = '0;
          w_src_sub   = 1'b0;
        end
      end
      RUN: begin
        w_issue = 1'b1;
      end
      DRAIN: begin
        if (r_drain == DCW'(RD_LATENCY)) begin
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_drain_nxt = r_drain + DCW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_cfg   = elem_cfg(w_src_elem);
    w_nelem = elem_next(w_src_elem);
    w_ncfg  = elem_cfg(w_nelem);

    // two-op elements read first, then write
    w_rd_op     = w_cfg.rd && !w_src_sub;
    w_last_sub  = w_src_sub ||
                  !(w_cfg.rd && w_cfg.wr);
    w_last_addr = w_cfg.up ?
                  (w_src_addr == LAST) :
                  (w_src_addr == '0);

    if (w_issue) begin
      w_cs_nxt    = 1'b1;
      w_we_nxt    = !w_rd_op;
      w_oaddr_nxt = w_src_addr[ADDRWIDTH-1:0];
      w_wdata_nxt = w_rd_op ? '0 :
                    {DATAWIDTH{w_cfg.wr_bg}};
      w_exp_nxt   = w_rd_op ?
                    {DATAWIDTH{w_cfg.rd_bg}} : '0;
      w_elem_nxt  = w_src_elem;
      w_addr_nxt  = w_src_addr;
      w_sub_nxt   = 1'b0;
      if (!w_last_sub) begin
        w_sub_nxt = 1'b1;
      end else if (!w_last_addr) begin
        w_addr_nxt = w_cfg.up ?
                     w_src_addr + ONE :
                     w_src_addr - ONE;
      end else if (w_src_elem == E5) begin
        w_state_nxt = DRAIN;
        w_drain_nxt = '0;
        w_elem_nxt  = E0;
        w_addr_nxt  = '0;
      end else begin
        w_elem_nxt = w_nelem;
        w_addr_nxt = w_ncfg.up ? '0 : LAST;
      end
    end
  end

  ram_bist_cmp #(
    .ADDRWIDTH  (ADDRWIDTH),
    .DATAWIDTH  (DATAWIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_vld       (r_cs && !r_we),
    .i_addr      (r_oaddr),
    .i_exp       (r_exp),
    .i_rdata     (ram.rdata),
    .o_fail      (fail),
    .o_fail_addr (fail_addr),
    .o_fail_data (fail_data)
  );

  assign ram.addr  = r_oaddr;
  assign ram.wdata = r_wdata;
  assign ram.cs    = r_cs;
  assign ram.we    = r_we;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ram_march_bist.sv
// tb_ram_march_bist: directed bench for ram_march_bist with a
// behavioural 1-cycle-latency RAM carrying stuck-at fault masks.
module tb_ram_march_bist;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int SIZE = 16;
  localparam int LAT  = 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  ram_bist_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus();

  ram_march_bist #(
    .ADDRWIDTH  (AW),
    .DATAWIDTH  (DW),
    .SIZE       (SIZE),
    .RD_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ram       (bus),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [SIZE];
  logic [DW-1:0] sa0 [SIZE];
  logic [DW-1:0] sa1 [SIZE];

  initial begin
    for (int i = 0; i < SIZE; i++) begin
      mem[i] = '0;
      sa0[i] = '0;
      sa1[i] = '0;
    end
    bus.rdata = '0;
  end

  always @(posedge clk) begin
    if (bus.cs) begin
      if (bus.we)
        mem[bus.addr] <= (bus.wdata & ~sa0[bus.addr])
                         | sa1[bus.addr];
      else
        bus.rdata <= (mem[bus.addr] & ~sa0[bus.addr])
                     | sa1[bus.addr];
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t trace[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic do_run(input bit mid,
                        output int lat,
                        output int ncs,
                        output logic f_busy,
                        output logic f_done,
                        output logic f_fail);
    int s;
    trace.delete();
    ncs = 0;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b0;
    @(negedge clk);
    f_busy = busy;
    f_done = done;
    f_fail = fail;
    for (int k = 0; k < 400; k++) begin
      if (bus.cs) begin
        ncs++;
        trace.push_back('{we:bus.we, addr:bus.addr,
                          wdata:bus.wdata});
      end
      if (done) begin
        lat = cyc - s;
        break;
      end
      if (mid && k == 30) start = 1'b1;
      if (mid && k == 31) start = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string         nm;
    logic [AW-1:0] a1;
    logic [DW-1:0] m0_1;
    logic [DW-1:0] m1_1;
    logic [AW-1:0] a2;
    logic [DW-1:0] m0_2;
    logic [DW-1:0] m1_2;
    logic          ef;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } rv_t;

  typedef struct {
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } tv_t;

  rv_t  rv [3];
  tv_t  tv [13];
  int   lat;
  int   ncs;
  logic fb;
  logic fd;
  logic ff;

  function automatic logic [28:0] all_out();
    return {bus.addr, bus.wdata, bus.cs, bus.we,
            busy, done, fail, fail_addr, fail_data};
  endfunction

  initial begin
    rv[0] = '{"clean", 4'd0, 8'h00, 8'h00,
              4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00};
    rv[1] = '{"sa0_a5_b3", 4'd5, 8'h08, 8'h00,
              4'd0, 8'h00, 8'h00, 1'b1, 4'd5, 8'hF7};
    rv[2] = '{"two_faults", 4'd2, 8'h00, 8'h01,
              4'd9, 8'h80, 8'h00, 1'b1, 4'd2, 8'h01};

    tv[0]  = '{0,   1'b1, 4'd0,  8'h00};
    tv[1]  = '{15,  1'b1, 4'd15, 8'h00};
    tv[2]  = '{16,  1'b0, 4'd0,  8'h00};
    tv[3]  = '{17,  1'b1, 4'd0,  8'hFF};
    tv[4]  = '{47,  1'b1, 4'd15, 8'hFF};
    tv[5]  = '{48,  1'b0, 4'd0,  8'h00};
    tv[6]  = '{49,  1'b1, 4'd0,  8'h00};
    tv[7]  = '{80,  1'b0, 4'd15, 8'h00};
    tv[8]  = '{81,  1'b1, 4'd15, 8'hFF};
    tv[9]  = '{82,  1'b0, 4'd14, 8'h00};
    tv[10] = '{113, 1'b1, 4'd15, 8'h00};
    tv[11] = '{144, 1'b0, 4'd0,  8'h00};
    tv[12] = '{159, 1'b0, 4'd15, 8'h00};

    start = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 chk("reset_outputs", 64'(all_out()), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 64'(all_out()), 64'd0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < SIZE; i++) begin
        sa0[i] = '0;
        sa1[i] = '0;
      end
      sa0[rv[r].a1] = rv[r].m0_1;
      sa1[rv[r].a1] = rv[r].m1_1;
      sa0[rv[r].a2] = sa0[rv[r].a2] | rv[r].m0_2;
      sa1[rv[r].a2] = sa1[rv[r].a2] | rv[r].m1_2;
      do_run(1'b0, lat, ncs, fb, fd, ff);
      chk({rv[r].nm, "_busy_rise"}, 64'(fb), 64'd1);
      chk({rv[r].nm, "_done_lat"}, 64'(lat), 64'd161);
      chk({rv[r].nm, "_ncs"}, 64'(ncs), 64'd160);
      chk({rv[r].nm, "_fail"}, 64'(fail), 64'(rv[r].ef));
      chk({rv[r].nm, "_faddr"}, 64'(fail_addr),
          64'(rv[r].ea));
      chk({rv[r].nm, "_fdata"}, 64'(fail_data),
          64'(rv[r].ed));
      chk({rv[r].nm, "_busy_end"}, 64'(busy), 64'd0);
      chk({rv[r].nm, "_cs_end"}, 64'(bus.cs), 64'd0);
      if (r == 0) begin
        chk("trace_len", 64'(trace.size()), 64'd160);
        for (int t = 0; t < 13; t++) begin
          if (trace.size() > tv[t].idx) begin
            chk($sformatf("op%0d_we", tv[t].idx),
                64'(trace[tv[t].idx].we), 64'(tv[t].we));
            chk($sformatf("op%0d_addr", tv[t].idx),
                64'(trace[tv[t].idx].addr), 64'(tv[t].addr));
            chk($sformatf("op%0d_wdata", tv[t].idx),
                64'(trace[tv[t].idx].wdata), 64'(tv[t].wd));
          end else begin
            chk($sformatf("op%0d_missing", tv[t].idx),
                64'(trace.size()), 64'(tv[t].idx + 1));
          end
        end
      end
      repeat (3) @(negedge clk);
      chk({rv[r].nm, "_done_hold"}, 64'(done), 64'd1);
      chk({rv[r].nm, "_fail_hold"}, 64'(fail), 64'(rv[r].ef));
    end

    for (int i = 0; i < SIZE; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
    do_run(1'b0, lat, ncs, fb, fd, ff);
    chk("restart_done_clr", 64'(fd), 64'd0);
    chk("restart_fail_clr", 64'(ff), 64'd0);
    chk("restart_busy", 64'(fb), 64'd1);
    chk("restart_lat", 64'(lat), 64'd161);
    chk("restart_fail", 64'(fail), 64'd0);
    chk("restart_faddr", 64'(fail_addr), 64'd0);

    do_run(1'b1, lat, ncs, fb, fd, ff);
    chk("midstart_lat", 64'(lat), 64'd161);
    chk("midstart_ncs", 64'(ncs), 64'd160);
    chk("midstart_fail", 64'(fail), 64'd0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1 chk("midreset_outputs", 64'(all_out()), 64'd0);
    @(negedge clk);
    chk("midreset_hold", 64'(all_out()), 64'd0);
    rst_n = 1'b1;
    do_run(1'b0, lat, ncs, fb, fd, ff);
    chk("postreset_lat", 64'(lat), 64'd161);
    chk("postreset_ncs", 64'(ncs), 64'd160);
    chk("postreset_fail", 64'(fail), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
